// File: rtl/mmio_pkg.sv
//------------------------------------------------------------------------------
// mmio_pkg -- shared FSM state type, default address map and error data. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mmio_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Slice [i*32 +: 32] belongs to target i.
  localparam logic [127:0] DEF_TGT_BASE  = {32'h0000_E57C, 32'h0000_040C,
                                            32'h0000_000C, 32'h0000_0004};
  localparam logic [127:0] DEF_TGT_LIMIT = {32'h0000_FFFC, 32'h0000_E578,
                                            32'h0000_0408, 32'h0000_0008};
  localparam logic [3:0]   DEF_WO_MASK   = 4'b1000;
  localparam logic [31:0]  ERR_RDATA     = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/mmio_addr_decode.sv
//------------------------------------------------------------------------------
// mmio_addr_decode -- priority region decode, write-only check, offset. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int                     NUM_TGT   = 4,
  parameter logic [NUM_TGT*32-1:0]  TGT_BASE  = DEF_TGT_BASE,
  parameter logic [NUM_TGT*32-1:0]  TGT_LIMIT = DEF_TGT_LIMIT,
  parameter logic [NUM_TGT-1:0]     WO_MASK   = DEF_WO_MASK
) (
  input  logic [31:0]         addr,
  input  logic                lw,
  output logic [NUM_TGT-1:0]  hit,
  output logic                wo_viol,
  output logic [31:0]         offset
);

  logic found;

  // Lowest index wins on overlapping regions.
  always_comb begin
    hit    = '0;
    offset = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (!found && addr >= TGT_BASE[i*32 +: 32] && addr <= TGT_LIMIT[i*32 +: 32]) begin
        hit[i] = 1'b1;
        offset = addr - TGT_BASE[i*32 +: 32];
        found  = 1'b1;
      end
    end
  end

  assign wo_viol = lw & (|(hit & WO_MASK));

endmodule

`default_nettype wire

// File: rtl/mmio_router.sv
//------------------------------------------------------------------------------
// mmio_router -- single-outstanding CPU-to-MMIO router; optional MMIO_TIMEOUT_EN
// adds a WAIT timeout that completes with cpu_err. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mmio_router
  import mmio_pkg::*;
#(
  parameter int                     NUM_TGT   = 4,
  parameter logic [NUM_TGT*32-1:0]  TGT_BASE  = DEF_TGT_BASE,
  parameter logic [NUM_TGT*32-1:0]  TGT_LIMIT = DEF_TGT_LIMIT,
  parameter logic [NUM_TGT-1:0]     WO_MASK   = DEF_WO_MASK,
  parameter int                     TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_lw,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [4:0]              cpu_regD,
  output logic                    cpu_ack,
  output logic                    cpu_err,
  output logic                    cpu_busy,
  output logic [31:0]             cpu_rdata,
  output logic [4:0]              cpu_regD_done,
  output logic [NUM_TGT-1:0]      tg_req,
  output logic                    tg_lw,
  output logic [31:0]             tg_addr,
  output logic [31:0]             tg_wdata,
  input  logic [NUM_TGT-1:0]      tg_ack,
  input  logic [NUM_TGT*32-1:0]   tg_rdata
);

  logic [NUM_TGT-1:0] dec_hit;
  logic               dec_wo;
  logic [31:0]        dec_offset;

  mmio_addr_decode #(
    .NUM_TGT   (NUM_TGT),
    .TGT_BASE  (TGT_BASE),
    .TGT_LIMIT (TGT_LIMIT),
    .WO_MASK   (WO_MASK)
  ) u_decode (
    .addr    (cpu_addr),
    .lw      (cpu_lw),
    .hit     (dec_hit),
    .wo_viol (dec_wo),
    .offset  (dec_offset)
  );

  state_t             state;
  logic               lw_q;
  logic [31:0]        wdata_q;
  logic [31:0]        offset_q;
  logic [4:0]         regd_q;
  logic [NUM_TGT-1:0] hit_q;
  logic [31:0]        sel_rdata;
  logic               ack_sel;
  logic               timeout_hit;

  assign tg_lw    = lw_q;
  assign tg_addr  = offset_q;
  assign tg_wdata = wdata_q;
  assign ack_sel  = |(tg_ack & hit_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (hit_q[i]) sel_rdata = tg_rdata[i*32 +: 32];
    end
  end

`ifdef MMIO_TIMEOUT_EN
  logic [31:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               wait_cnt <= '0;
    else if (state == S_WAIT) wait_cnt <= wait_cnt + 32'd1;
    else                      wait_cnt <= '0;
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == 32'(TIMEOUT - 1));
`else
  // Without the counter WAIT only leaves on an ack; TIMEOUT has no effect.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lw_q          <= 1'b0;
      wdata_q       <= '0;
      offset_q      <= '0;
      regd_q        <= '0;
      hit_q         <= '0;
      tg_req        <= '0;
      cpu_ack       <= 1'b0;
      cpu_err       <= 1'b0;
      cpu_busy      <= 1'b0;
      cpu_rdata     <= '0;
      cpu_regD_done <= '0;
    end else begin
      tg_req        <= '0;
      cpu_ack       <= 1'b0;
      cpu_err       <= 1'b0;
      cpu_rdata     <= '0;
      cpu_regD_done <= '0;
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            lw_q     <= cpu_lw;
            wdata_q  <= cpu_wdata;
            offset_q <= dec_offset;
            regd_q   <= cpu_regD;
            hit_q    <= dec_hit;
            if (dec_hit == '0 || dec_wo) begin
              state     <= S_RESP;
              cpu_err   <= 1'b1;
              cpu_rdata <= cpu_lw ? ERR_RDATA : 32'h0;
            end else begin
              state    <= S_ISSUE;
              tg_req   <= dec_hit;
              cpu_busy <= 1'b1;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          if (ack_sel) begin
            state    <= S_RESP;
            cpu_busy <= 1'b0;
            cpu_ack  <= 1'b1;
            if (lw_q) begin
              cpu_rdata     <= sel_rdata;
              cpu_regD_done <= regd_q;
            end
          end else if (timeout_hit) begin
            state     <= S_RESP;
            cpu_busy  <= 1'b0;
            cpu_err   <= 1'b1;
            cpu_rdata <= lw_q ? ERR_RDATA : 32'h0;
          end else begin
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_router.sv
//------------------------------------------------------------------------------
// tb_mmio_router -- directed self-checking bench for mmio_router. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mmio_router;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_lw;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [4:0]   cpu_regD;
  logic         cpu_ack, cpu_err, cpu_busy;
  logic [31:0]  cpu_rdata;
  logic [4:0]   cpu_regD_done;
  logic [3:0]   tg_req;
  logic         tg_lw;
  logic [31:0]  tg_addr, tg_wdata;
  logic [3:0]   tg_ack;
  logic [127:0] tg_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int nwait;

  always #5 clk = ~clk;

  mmio_router #(.NUM_TGT(4), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req       (cpu_req),
    .cpu_lw        (cpu_lw),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_regD      (cpu_regD),
    .cpu_ack       (cpu_ack),
    .cpu_err       (cpu_err),
    .cpu_busy      (cpu_busy),
    .cpu_rdata     (cpu_rdata),
    .cpu_regD_done (cpu_regD_done),
    .tg_req        (tg_req),
    .tg_lw         (tg_lw),
    .tg_addr       (tg_addr),
    .tg_wdata      (tg_wdata),
    .tg_ack        (tg_ack),
    .tg_rdata      (tg_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic lw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] regd);
    cpu_req   = 1'b1;
    cpu_lw    = lw;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_regD  = regd;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_lw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_regD = '0; tg_ack = '0;
    tg_rdata = {32'h3333_3333, 32'h2222_2222, 32'h0000_AAAA, 32'h0000_0055};
    repeat (2) tick();
    check("rst_busy",  32'(cpu_busy), 0);
    check("rst_ack",   32'(cpu_ack), 0);
    check("rst_err",   32'(cpu_err), 0);
    check("rst_tgreq", 32'(tg_req), 0);
    check("rst_rdata", cpu_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Store 0x20 -> target 1, offset 0x14; unselected ack ignored
    request(1'b0, 32'h20, 32'hDEAD_BEEF, 5'd0);
    check("st_tgreq",  32'(tg_req), 32'h2);
    check("st_tgaddr", tg_addr, 32'h14);
    check("st_wdata",  tg_wdata, 32'hDEAD_BEEF);
    check("st_tglw",   32'(tg_lw), 0);
    check("st_busy",   32'(cpu_busy), 1);
    tg_ack = 4'b0001;
    tick();
    check("st_reqpulse", 32'(tg_req), 0);
    tick();
    check("st_unsel_ack", 32'(cpu_ack), 0);
    check("st_unsel_busy", 32'(cpu_busy), 1);
    tg_ack = 4'b0010;
    tick();
    check("st_ack",    32'(cpu_ack), 1);
    check("st_err",    32'(cpu_err), 0);
    check("st_busy_r", 32'(cpu_busy), 0);
    check("st_rdata",  cpu_rdata, 0);
    tg_ack = 4'b0000;
    tick();
    check("st_ack_1cyc", 32'(cpu_ack), 0);
    check("resp_noacc_req", 32'(tg_req), 0);
    cpu_req = 1'b0;
    tick();
    check("resp_noacc_busy", 32'(cpu_busy), 0);

    // Load 0x4, ack in ISSUE
    request(1'b1, 32'h4, 32'h0, 5'd7);
    check("ld_tgreq",  32'(tg_req), 32'h1);
    check("ld_tgaddr", tg_addr, 0);
    check("ld_tglw",   32'(tg_lw), 1);
    tg_ack = 4'b0001;
    tick();
    check("ld_ack",   32'(cpu_ack), 1);
    check("ld_rdata", cpu_rdata, 32'h55);
    check("ld_regd",  32'(cpu_regD_done), 7);
    tg_ack = 4'b0000;
    tick();
    check("ld_rdata_clr", cpu_rdata, 0);
    check("ld_regd_clr",  32'(cpu_regD_done), 0);
    cpu_req = 1'b0;
    tick();

    // Unmapped load
    request(1'b1, 32'h0, 32'h0, 5'd4);
    check("um_tgreq", 32'(tg_req), 0);
    check("um_err",   32'(cpu_err), 1);
    check("um_ack",   32'(cpu_ack), 0);
    check("um_rdata", cpu_rdata, 32'hFFFF_FFFF);
    check("um_regd",  32'(cpu_regD_done), 0);
    check("um_busy",  32'(cpu_busy), 0);
    cpu_req = 1'b0;
    tick();
    check("um_err_clr", 32'(cpu_err), 0);

    // Write-only target: load errors, store goes through
    request(1'b1, 32'hE580, 32'h0, 5'd9);
    check("wo_ld_err",   32'(cpu_err), 1);
    check("wo_ld_rdata", cpu_rdata, 32'hFFFF_FFFF);
    check("wo_ld_tgreq", 32'(tg_req), 0);
    cpu_req = 1'b0;
    tick();
    request(1'b0, 32'hE580, 32'h1234, 5'd0);
    check("wo_st_tgreq",  32'(tg_req), 32'h8);
    check("wo_st_tgaddr", tg_addr, 32'h4);
    tick();
    tg_ack = 4'b1000;
    tick();
    check("wo_st_ack", 32'(cpu_ack), 1);
    tg_ack = 4'b0000; cpu_req = 1'b0;
    tick();

    // Inclusive limit of target 1, then the gap just above it
    request(1'b0, 32'h408, 32'h5, 5'd0);
    check("lim_tgreq",  32'(tg_req), 32'h2);
    check("lim_tgaddr", tg_addr, 32'h3FC);
    tg_ack = 4'b0010;
    tick();
    check("lim_ack", 32'(cpu_ack), 1);
    tg_ack = 4'b0000; cpu_req = 1'b0;
    tick();
    request(1'b0, 32'h409, 32'h5, 5'd0);
    check("gap_err",   32'(cpu_err), 1);
    check("gap_rdata", cpu_rdata, 0);
    cpu_req = 1'b0;
    tick();

    // Reset during WAIT, ack right after release ignored, then normal load
    request(1'b0, 32'h40C, 32'h77, 5'd0);
    check("rw_tgreq", 32'(tg_req), 32'h4);
    tick();
    rst_n = 1'b0;
    #1;
    check("rw_busy",  32'(cpu_busy), 0);
    check("rw_wdata", tg_wdata, 0);
    check("rw_addr",  tg_addr, 0);
    cpu_req = 1'b0;
    tick();
    rst_n  = 1'b1;
    tg_ack = 4'b0100;
    tick();
    check("rw_postack_busy", 32'(cpu_busy), 0);
    check("rw_postack_ack",  32'(cpu_ack), 0);
    tg_ack = 4'b0000;
    tg_rdata[63:32] = 32'h0000_CAFE;
    request(1'b1, 32'h10, 32'h0, 5'd3);
    check("rw_ld_tgreq",  32'(tg_req), 32'h2);
    check("rw_ld_tgaddr", tg_addr, 32'h4);
    tg_ack = 4'b0010;
    tick();
    check("rw_ld_rdata", cpu_rdata, 32'h0000_CAFE);
    check("rw_ld_regd",  32'(cpu_regD_done), 3);
    tg_ack = 4'b0000; cpu_req = 1'b0;
    tick();

`ifdef MMIO_TIMEOUT_EN
    // No ack: error after 8 WAIT cycles, late ack ignored
    request(1'b1, 32'h4, 32'h0, 5'd5);
    nwait = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (cpu_err || cpu_ack) break;
      nwait++;
    end
    check("to_waits", 32'(nwait), 8);
    check("to_err",   32'(cpu_err), 1);
    check("to_rdata", cpu_rdata, 32'hFFFF_FFFF);
    check("to_regd",  32'(cpu_regD_done), 0);
    cpu_req = 1'b0;
    tick();
    tg_ack = 4'b0001;
    tick();
    check("to_late_ack",  32'(cpu_ack), 0);
    check("to_late_busy", 32'(cpu_busy), 0);
    tg_ack = 4'b0000;
    tick();
`else
    // Without the timeout, WAIT holds until the ack arrives
    request(1'b1, 32'h4, 32'h0, 5'd5);
    repeat (30) tick();
    check("nt_busy", 32'(cpu_busy), 1);
    check("nt_err",  32'(cpu_err), 0);
    tg_ack = 4'b0001;
    tick();
    check("nt_ack",   32'(cpu_ack), 1);
    check("nt_rdata", cpu_rdata, 32'h55);
    tg_ack = 4'b0000; cpu_req = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
